// File: rtl/alu_uart_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_uart_ctrl_if
//   Bundles the byte handshakes between the UART, the ALU and the sequencer
//   (alu_uart_ctrl). The i_/o_ prefixes are given from the sequencer's point of
//   view.
//
//   Modports:
//     slave  : the sequencer. It consumes the UART ticks, the received byte and
//              the ALU result, and drives operands, opcode, tx request and
//              status pulses.
//     master : the surrounding environment (UART, ALU or testbench). It drives
//              the i_* signals and observes the o_* signals.
//
//   Parameters:
//     NB_DATA : data, operand and result width in bits
//     NB_OP   : opcode width in bits
// -----------------------------------------------------------------------------
interface alu_uart_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);

  logic               i_rx_done_tick;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_tx_done_tick;
  logic [NB_DATA-1:0] i_alu_result;

  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_busy;
  logic               o_rx_drop;
  logic               o_timeout;

  modport master (
    output i_rx_done_tick,
    output i_rx_data,
    output i_tx_done_tick,
    output i_alu_result,
    input  o_data_a,
    input  o_data_b,
    input  o_op,
    input  o_tx_start,
    input  o_tx_data,
    input  o_busy,
    input  o_rx_drop,
    input  o_timeout
  );

  modport slave (
    input  i_rx_done_tick,
    input  i_rx_data,
    input  i_tx_done_tick,
    input  i_alu_result,
    output o_data_a,
    output o_data_b,
    output o_op,
    output o_tx_start,
    output o_tx_data,
    output o_busy,
    output o_rx_drop,
    output o_timeout
  );

endinterface

// File: rtl/alu_uart_ctrl.sv
// -----------------------------------------------------------------------------
// alu_uart_ctrl
//   Sequencer between the UART byte handshakes and the combinational ALU.
//   It receives three bytes in order (operand A, operand B, opcode), presents
//   them to the ALU, captures the ALU result one cycle later and requests its
//   transmission. One transaction is in flight at a time.
//
//   Ports:
//     i_clk   : system clock, all logic on the rising edge
//     i_reset : synchronous, active-high reset
//     bus     : alu_uart_ctrl_if.slave
//               in : i_rx_done_tick, i_rx_data, i_tx_done_tick, i_alu_result
//               out: o_data_a, o_data_b, o_op, o_tx_start, o_tx_data,
//                    o_busy, o_rx_drop, o_timeout
//
//   Parameters:
//     NB_DATA        : data width (must match the interface)
//     NB_OP          : opcode width, taken from the low bits of the opcode byte
//     TIMEOUT_CYCLES : clocks allowed between bytes of one transaction;
//                      present only when ALU_UART_TIMEOUT_EN is defined
//
//   Build option:
//     ALU_UART_TIMEOUT_EN : when defined, an inter-byte watchdog runs in
//       WAIT_B/WAIT_OP and aborts a stalled transaction with an o_timeout
//       pulse. When undefined no counter is built and o_timeout is tied low.
//
//   All outputs come straight from flops; there is no combinational path from
//   any input to any output.
// -----------------------------------------------------------------------------
module alu_uart_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
`ifdef ALU_UART_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 50000000
`endif
) (
  input  logic           i_clk,
  input  logic           i_reset,
  alu_uart_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CAPTURE = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t state, state_next;

  // Registered outputs
  logic [NB_DATA-1:0] data_a_q;
  logic [NB_DATA-1:0] data_b_q;
  logic [NB_OP-1:0]   op_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               rx_drop_q;

  // Decisions made by the next-state logic for the datapath register
  logic load_a;
  logic load_b;
  logic load_op;
  logic load_res;
  logic rx_drop;

  // High in the last allowed idle cycle of WAIT_B/WAIT_OP
  logic tmo_hit;

  // ---------------------------------------------------------------------------
  // Next-state and datapath-control logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would infer a latch.
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    load_res   = 1'b0;
    rx_drop    = 1'b0;

    unique case (state)
      WAIT_A: begin
        if (bus.i_rx_done_tick) begin
          load_a     = 1'b1;
          state_next = WAIT_B;
        end
      end

      // A byte arriving in the watchdog's last cycle wins over the timeout.
      WAIT_B: begin
        if (bus.i_rx_done_tick) begin
          load_b     = 1'b1;
          state_next = WAIT_OP;
        end else if (tmo_hit) begin
          state_next = WAIT_A;
        end
      end

      WAIT_OP: begin
        if (bus.i_rx_done_tick) begin
          load_op    = 1'b1;
          state_next = CAPTURE;
        end else if (tmo_hit) begin
          state_next = WAIT_A;
        end
      end

      // The ALU has had one full cycle on the registered operands by now.
      CAPTURE: begin
        load_res   = 1'b1;
        rx_drop    = bus.i_rx_done_tick;
        state_next = SEND;
      end

      SEND: begin
        rx_drop    = bus.i_rx_done_tick;
        state_next = WAIT_TX;
      end

      // A byte coinciding with the tx-done tick still belongs to the old
      // transaction and is dropped; the next cycle is already WAIT_A.
      WAIT_TX: begin
        rx_drop = bus.i_rx_done_tick;
        if (bus.i_tx_done_tick) begin
          state_next = WAIT_A;
        end
      end

      default: state_next = WAIT_A;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      state <= state_next;

      if (load_a)   data_a_q  <= bus.i_rx_data;
      if (load_b)   data_b_q  <= bus.i_rx_data;
      if (load_op)  op_q      <= bus.i_rx_data[NB_OP-1:0];
      if (load_res) tx_data_q <= bus.i_alu_result;

      // Flags are derived from the state being entered so that they line up
      // with the state itself while remaining registered.
      tx_start_q <= (state_next == SEND);
      busy_q     <= (state_next != WAIT_A);
      rx_drop_q  <= rx_drop;
    end
  end

  assign bus.o_data_a   = data_a_q;
  assign bus.o_data_b   = data_b_q;
  assign bus.o_op       = op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_rx_drop  = rx_drop_q;

`ifdef ALU_UART_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Inter-byte watchdog
  //   Counts idle cycles in WAIT_B/WAIT_OP. It is zero on entry to WAIT_B
  //   (cleared by the accepted operand A) and is cleared again by operand B,
  //   so each gap gets the full TIMEOUT_CYCLES budget. The abort edge is the
  //   one that sees the count at TIMEOUT_CYCLES-1 with no byte present.
  // ---------------------------------------------------------------------------
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout_q;
  logic             in_gap;

  assign in_gap  = (state == WAIT_B) || (state == WAIT_OP);
  assign tmo_hit = in_gap && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit && !bus.i_rx_done_tick;
      if (in_gap && !bus.i_rx_done_tick && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  assign tmo_hit       = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

endmodule
